// File: rtl/pc_ctrl_pkg.sv
// Shared types and defaults for the next-PC / stall / flush controller.
//   state_t      : controller FSM states
//   redir_kind_t : redirect kinds, numerically ordered by priority so the
//                  pending buffer can compare them with '>'
package pc_ctrl_pkg;

  typedef enum logic [1:0] {RUN, TRAP, STALL, HALT} state_t;

  typedef enum logic [2:0] {R_NONE, R_JUMP, R_BR, R_MRET, R_TRAP} redir_kind_t;

  localparam int unsigned PC_STEP_DEF  = 4;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

endpackage

// File: rtl/redirect_arb.sv
// Combinational redirect priority encoder: trap > mret > ex_br > id_jump.
// Inputs : the four request pulses with their targets.
// Outputs: kind   - winning redirect kind (R_NONE if nothing requested)
//          target - PC to fetch for that redirect (trap -> handler vector)
module redirect_arb
  import pc_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              trap_req,
  input  logic [DATA_W-1:0] trap_vector,
  input  logic              mret_req,
  input  logic [DATA_W-1:0] mepc,
  input  logic              ex_br_req,
  input  logic [DATA_W-1:0] ex_br_target,
  input  logic              id_jump_req,
  input  logic [DATA_W-1:0] id_jump_target,
  output redir_kind_t       kind,
  output logic [DATA_W-1:0] target
);

  always_comb begin
    kind   = R_NONE;
    target = '0;
    if (trap_req) begin
      kind   = R_TRAP;
      target = trap_vector;
    end else if (mret_req) begin
      kind   = R_MRET;
      target = mepc;
    end else if (ex_br_req) begin
      kind   = R_BR;
      target = ex_br_target;
    end else if (id_jump_req) begin
      kind   = R_JUMP;
      target = id_jump_target;
    end
  end

endmodule

// File: rtl/pc_flow_ctrl.sv
// Next-PC sequencer and stall/flush controller for the 5-stage core.
// Inputs : pc_in, redirect requests (trap/mret/ex_br/id_jump) with targets,
//          load_use, mem_busy, halt_req/resume, stall_cnt_clr.
// Outputs: new_pc/pc_stall to the PC register, IF/ID and ID/EX flush/stall,
//          pipe_freeze, epc_we/epc_out to the CSR file, stall_cnt counter.
// All control outputs are combinational (the PC register samples on negedge).
module pc_flow_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] RESET_PC = DATA_W'(RESET_PC_DEF),
  parameter int unsigned       PC_STEP  = PC_STEP_DEF,
  parameter int                CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pc_in,
  input  logic              trap_req,
  input  logic [DATA_W-1:0] trap_pc,
  input  logic [DATA_W-1:0] trap_vector,
  input  logic              mret_req,
  input  logic [DATA_W-1:0] mepc,
  input  logic              ex_br_req,
  input  logic [DATA_W-1:0] ex_br_target,
  input  logic              id_jump_req,
  input  logic [DATA_W-1:0] id_jump_target,
  input  logic              load_use,
  input  logic              mem_busy,
  input  logic              halt_req,
  input  logic              resume,
  input  logic              stall_cnt_clr,
  output logic [DATA_W-1:0] new_pc,
  output logic              pc_stall,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              if_id_stall,
  output logic              pipe_freeze,
  output logic              epc_we,
  output logic [DATA_W-1:0] epc_out,
  output logic [CNT_W-1:0]  stall_cnt
);

  state_t            state_q, state_d;
  redir_kind_t       pend_kind_q, pend_kind_d;
  logic [DATA_W-1:0] pend_tgt_q, pend_tgt_d;

  redir_kind_t       cur_kind, eff_kind;
  logic [DATA_W-1:0] cur_tgt, eff_tgt, seq_pc;

  redirect_arb #(.DATA_W(DATA_W)) u_arb (
    .trap_req       (trap_req),
    .trap_vector    (trap_vector),
    .mret_req       (mret_req),
    .mepc           (mepc),
    .ex_br_req      (ex_br_req),
    .ex_br_target   (ex_br_target),
    .id_jump_req    (id_jump_req),
    .id_jump_target (id_jump_target),
    .kind           (cur_kind),
    .target         (cur_tgt)
  );

  assign seq_pc = pc_in + DATA_W'(PC_STEP);

  // On stall release the buffered redirect competes with anything new;
  // in RUN the buffer is always empty so this reduces to the live request.
  always_comb begin
    if (pend_kind_q > cur_kind) begin
      eff_kind = pend_kind_q;
      eff_tgt  = pend_tgt_q;
    end else begin
      eff_kind = cur_kind;
      eff_tgt  = cur_tgt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      pend_kind_q <= R_NONE;
      pend_tgt_q  <= '0;
    end else begin
      state_q     <= state_d;
      pend_kind_q <= pend_kind_d;
      pend_tgt_q  <= pend_tgt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pend_kind_d = pend_kind_q;
    pend_tgt_d  = pend_tgt_q;
    new_pc      = seq_pc;
    pc_stall    = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if_id_stall = 1'b0;
    pipe_freeze = 1'b0;
    epc_we      = 1'b0;
    epc_out     = '0;

    case (state_q)
      TRAP: begin
        // Second trap cycle: fetch the handler, drop whatever is in IF/ID.
        new_pc      = trap_vector;
        if_id_flush = 1'b1;
        state_d     = RUN;
      end
      HALT: begin
        if (resume) begin
          state_d = RUN;
        end else begin
          new_pc      = pc_in;
          pc_stall    = 1'b1;
          pipe_freeze = 1'b1;
        end
      end
      default: begin // RUN, STALL
        if (trap_req) begin
          // Trap beats mem_busy and discards any buffered redirect.
          new_pc      = pc_in;
          pc_stall    = 1'b1;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          epc_we      = 1'b1;
          epc_out     = trap_pc;
          pend_kind_d = R_NONE;
          state_d     = TRAP;
        end else if (mem_busy) begin
          new_pc      = pc_in;
          pc_stall    = 1'b1;
          pipe_freeze = 1'b1;
          state_d     = STALL;
          if (cur_kind > pend_kind_q) begin
            pend_kind_d = cur_kind;
            pend_tgt_d  = cur_tgt;
          end
        end else begin
          state_d     = RUN;
          pend_kind_d = R_NONE;
          case (eff_kind)
            R_MRET, R_BR: begin
              // Overrides load_use: the stalled instruction is squashed anyway.
              new_pc      = eff_tgt;
              if_id_flush = 1'b1;
              id_ex_flush = 1'b1;
            end
            default: begin
              if (load_use) begin
                // Any jump is dropped; ID re-presents it next cycle.
                new_pc      = pc_in;
                pc_stall    = 1'b1;
                if_id_stall = 1'b1;
                id_ex_flush = 1'b1;
              end else if (eff_kind == R_JUMP) begin
                new_pc      = eff_tgt;
                if_id_flush = 1'b1;
              end else if (halt_req && state_q == RUN) begin
                state_d = HALT;
              end
            end
          endcase
        end
      end
    endcase

    // Reset forces quiet outputs immediately, not just at the next edge.
    if (!rst) begin
      new_pc      = RESET_PC;
      pc_stall    = 1'b0;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      if_id_stall = 1'b0;
      pipe_freeze = 1'b0;
      epc_we      = 1'b0;
      epc_out     = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stall_cnt <= '0;
    else if (stall_cnt_clr)
      stall_cnt <= '0;
    else if (pc_stall && !(&stall_cnt))
      stall_cnt <= stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_pc_flow_ctrl.sv
module tb_pc_flow_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc_in, trap_pc, trap_vector, mepc, ex_br_target, id_jump_target;
  logic        trap_req, mret_req, ex_br_req, id_jump_req;
  logic        load_use, mem_busy, halt_req, resume, stall_cnt_clr;

  logic [31:0] new_pc, epc_out, stall_cnt;
  logic        pc_stall, if_id_flush, id_ex_flush, if_id_stall, pipe_freeze, epc_we;

  logic [31:0] new_pc4, epc_out4;
  logic [3:0]  stall_cnt4;
  logic        pc_stall4, if_id_flush4, id_ex_flush4, if_id_stall4, pipe_freeze4, epc_we4;

  logic [5:0] fl;
  assign fl = {pc_stall, if_id_flush, id_ex_flush, if_id_stall, pipe_freeze, epc_we};

  always #5 clk = ~clk;

  pc_flow_ctrl u_dut (
    .clk(clk), .rst(rst), .pc_in(pc_in),
    .trap_req(trap_req), .trap_pc(trap_pc), .trap_vector(trap_vector),
    .mret_req(mret_req), .mepc(mepc),
    .ex_br_req(ex_br_req), .ex_br_target(ex_br_target),
    .id_jump_req(id_jump_req), .id_jump_target(id_jump_target),
    .load_use(load_use), .mem_busy(mem_busy), .halt_req(halt_req), .resume(resume),
    .stall_cnt_clr(stall_cnt_clr),
    .new_pc(new_pc), .pc_stall(pc_stall), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .if_id_stall(if_id_stall), .pipe_freeze(pipe_freeze),
    .epc_we(epc_we), .epc_out(epc_out), .stall_cnt(stall_cnt)
  );

  // Narrow-counter build to exercise saturation.
  pc_flow_ctrl #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .pc_in(pc_in),
    .trap_req(trap_req), .trap_pc(trap_pc), .trap_vector(trap_vector),
    .mret_req(mret_req), .mepc(mepc),
    .ex_br_req(ex_br_req), .ex_br_target(ex_br_target),
    .id_jump_req(id_jump_req), .id_jump_target(id_jump_target),
    .load_use(load_use), .mem_busy(mem_busy), .halt_req(halt_req), .resume(resume),
    .stall_cnt_clr(stall_cnt_clr),
    .new_pc(new_pc4), .pc_stall(pc_stall4), .if_id_flush(if_id_flush4),
    .id_ex_flush(id_ex_flush4), .if_id_stall(if_id_stall4), .pipe_freeze(pipe_freeze4),
    .epc_we(epc_we4), .epc_out(epc_out4), .stall_cnt(stall_cnt4)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    trap_req = 1'b0; mret_req = 1'b0; ex_br_req = 1'b0; id_jump_req = 1'b0;
    load_use = 1'b0; mem_busy = 1'b0; halt_req = 1'b0; resume = 1'b0;
    stall_cnt_clr = 1'b0;
    trap_pc = '0; trap_vector = '0; mepc = '0; ex_br_target = '0; id_jump_target = '0;
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  // flags = {pc_stall, if_id_flush, id_ex_flush, if_id_stall, pipe_freeze, epc_we}
  typedef struct {
    logic [31:0] pc;
    logic        br;   logic [31:0] br_t;
    logic        jmp;  logic [31:0] jmp_t;
    logic        mret; logic [31:0] mepc_v;
    logic        lu;
    logic [31:0] exp_pc;
    logic [5:0]  exp_fl;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h44, 6'b000000};
    vecs[1] = '{32'h44, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h0, 1'b1, 32'h100, 6'b011000};
    vecs[2] = '{32'h48, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 32'h80, 1'b0, 32'h80, 6'b011000};
    vecs[3] = '{32'h4C, 1'b0, 32'h0, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0, 32'h200, 6'b010000};
    vecs[4] = '{32'h20, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h20, 6'b101100};
    vecs[5] = '{32'h20, 1'b0, 32'h0, 1'b1, 32'h200, 1'b0, 32'h0, 1'b1, 32'h20, 6'b101100};
    vecs[6] = '{32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 6'b000000};
    vecs[7] = '{32'h50, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h90, 1'b1, 32'h90, 6'b011000};

    // Reset state
    idle();
    pc_in = 32'h40;
    #3;
    chk("rst_new_pc", new_pc, 32'h0);
    chk("rst_flags", 32'(fl), 32'h0);
    chk("rst_epc_out", epc_out, 32'h0);
    chk("rst_stall_cnt", stall_cnt, 32'h0);
    nxt();
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_seq", new_pc, 32'h44);

    // Single-cycle RUN vectors
    for (int i = 0; i < 8; i++) begin
      nxt();
      idle();
      pc_in = vecs[i].pc;
      ex_br_req = vecs[i].br;    ex_br_target = vecs[i].br_t;
      id_jump_req = vecs[i].jmp; id_jump_target = vecs[i].jmp_t;
      mret_req = vecs[i].mret;   mepc = vecs[i].mepc_v;
      load_use = vecs[i].lu;
      @(negedge clk);
      chk($sformatf("vec%0d_new_pc", i), new_pc, vecs[i].exp_pc);
      chk($sformatf("vec%0d_flags", i), 32'(fl), 32'(vecs[i].exp_fl));
    end

    // Load-use then sequential
    nxt(); idle(); pc_in = 32'h20; load_use = 1'b1;
    @(negedge clk);
    chk("lu_flags", 32'(fl), 32'(6'b101100));
    nxt(); idle(); pc_in = 32'h20;
    @(negedge clk);
    chk("lu_after_pc", new_pc, 32'h24);

    // Trap sequence (a branch alongside must lose, and be ignored in TRAP)
    nxt(); idle(); pc_in = 32'h84;
    trap_req = 1'b1; trap_pc = 32'h88; trap_vector = 32'h1C0;
    ex_br_req = 1'b1; ex_br_target = 32'h999;
    @(negedge clk);
    chk("trap0_flags", 32'(fl), 32'(6'b111001));
    chk("trap0_epc_out", epc_out, 32'h88);
    nxt(); trap_req = 1'b0; trap_pc = '0; pc_in = 32'h88;
    @(negedge clk);
    chk("trap1_new_pc", new_pc, 32'h1C0);
    chk("trap1_flags", 32'(fl), 32'(6'b010000));
    nxt(); idle(); pc_in = 32'h1C0;
    @(negedge clk);
    chk("trap2_new_pc", new_pc, 32'h1C4);
    chk("trap2_flags", 32'(fl), 32'h0);

    // Buffered redirect during stall: jump then higher-priority branch
    nxt(); idle(); stall_cnt_clr = 1'b1;
    nxt(); idle(); mem_busy = 1'b1; pc_in = 32'h1C4;
    @(negedge clk);
    chk("stall_c0_flags", 32'(fl), 32'(6'b100010));
    nxt(); id_jump_req = 1'b1; id_jump_target = 32'h300;
    @(negedge clk);
    chk("stall_c1_flags", 32'(fl), 32'(6'b100010));
    nxt(); id_jump_req = 1'b0; ex_br_req = 1'b1; ex_br_target = 32'h500;
    @(negedge clk);
    chk("stall_c2_flags", 32'(fl), 32'(6'b100010));
    nxt(); idle();
    @(negedge clk);
    chk("stall_rel_new_pc", new_pc, 32'h500);
    chk("stall_rel_flags", 32'(fl), 32'(6'b011000));
    chk("stall_cnt_3", stall_cnt, 32'd3);
    chk("stall_cnt4_3", 32'(stall_cnt4), 32'd3);
    nxt(); idle(); pc_in = 32'h500;
    @(negedge clk);
    chk("stall_after_seq", new_pc, 32'h504);

    // Lower-priority request during stall is dropped
    nxt(); idle(); mem_busy = 1'b1; ex_br_req = 1'b1; ex_br_target = 32'h600;
    nxt(); idle(); mem_busy = 1'b1; id_jump_req = 1'b1; id_jump_target = 32'h700;
    nxt(); idle(); pc_in = 32'h504;
    @(negedge clk);
    chk("pend_keep_br", new_pc, 32'h600);

    // Halt / resume
    nxt(); idle(); pc_in = 32'h30; halt_req = 1'b1;
    @(negedge clk);
    chk("halt_entry_pc", new_pc, 32'h34);
    nxt(); idle(); pc_in = 32'h34;
    @(negedge clk);
    chk("halt_hold_flags", 32'(fl), 32'(6'b100010));
    nxt(); idle(); pc_in = 32'h34; resume = 1'b1;
    @(negedge clk);
    chk("resume_pc", new_pc, 32'h38);
    chk("resume_flags", 32'(fl), 32'h0);

    // Counter saturation (4-bit build) and clear priority
    nxt(); idle(); stall_cnt_clr = 1'b1;
    nxt(); idle(); mem_busy = 1'b1;
    repeat (19) nxt();
    nxt(); idle(); pc_in = 32'h40;
    @(negedge clk);
    chk("cnt_20", stall_cnt, 32'd20);
    chk("cnt4_sat", 32'(stall_cnt4), 32'hF);
    nxt(); idle(); mem_busy = 1'b1; stall_cnt_clr = 1'b1;
    nxt(); idle(); pc_in = 32'h40;
    @(negedge clk);
    chk("cnt_clr_prio", stall_cnt, 32'd0);
    chk("cnt4_clr_prio", 32'(stall_cnt4), 32'd0);

    // Async reset mid-STALL with a pending jump
    nxt(); idle(); mem_busy = 1'b1; pc_in = 32'h60;
    id_jump_req = 1'b1; id_jump_target = 32'h300;
    nxt(); idle(); mem_busy = 1'b1; pc_in = 32'h60;
    #2 rst = 1'b0;
    #1;
    chk("rst_stall_new_pc", new_pc, 32'h0);
    chk("rst_stall_flags", 32'(fl), 32'h0);
    nxt(); rst = 1'b1; idle(); pc_in = 32'h60;
    @(negedge clk);
    chk("rst_stall_seq", new_pc, 32'h64);
    chk("rst_stall_seq_fl", 32'(fl), 32'h0);

    // Async reset mid-TRAP
    nxt(); idle(); pc_in = 32'h70; trap_req = 1'b1; trap_pc = 32'h70; trap_vector = 32'h1C0;
    nxt(); idle(); pc_in = 32'h70;
    #2 rst = 1'b0;
    #1;
    chk("rst_trap_new_pc", new_pc, 32'h0);
    chk("rst_trap_flags", 32'(fl), 32'h0);
    nxt(); rst = 1'b1; idle(); pc_in = 32'h70;
    @(negedge clk);
    chk("rst_trap_seq", new_pc, 32'h74);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_flow_ctrl.md
Name: pc_flow_ctrl

Overview:
Next-PC sequencer and stall/flush controller for the 5-stage core. It arbitrates redirect requests (trap, mret, EX branch mispredict, ID jump) against sequential fetch and resolves load-use and memory-busy stalls. It drives the program counter register's next-PC and stall inputs, plus the IF/ID and ID/EX flush and stall controls. A redirect that arrives during a memory stall is buffered and applied when the stall releases.

Parameters:
DATA_W, 32, PC/target width (matches `DATA_WID).
RESET_PC, 32'h0000_0000, new_pc value after reset.
PC_STEP, 4, sequential increment.
CNT_W, 32, stall performance counter width.

Ports:
clk  in  1  core clock; state updates on posedge.
rst  in  1  asynchronous, active-low reset (asserted when 0).
pc_in  in  DATA_W  current PC from the PC register.
trap_req  in  1  exception/ecall taken (1-cycle pulse).
trap_pc  in  DATA_W  PC of the faulting instruction.
trap_vector  in  DATA_W  handler address.
mret_req  in  1  mret in EX (pulse).
mepc  in  DATA_W  return address.
ex_br_req  in  1  EX branch mispredict / taken (pulse).
ex_br_target  in  DATA_W  branch target.
id_jump_req  in  1  jal in ID (pulse).
id_jump_target  in  DATA_W  jump target.
load_use  in  1  load-use hazard detected in ID.
mem_busy  in  1  data memory not ready; freeze the pipeline.
halt_req  in  1  enter halt.
resume  in  1  leave halt.
stall_cnt_clr  in  1  synchronous clear of stall_cnt.
new_pc  out  DATA_W  next PC.
pc_stall  out  1  1 = hold PC (drives PC_Write).
if_id_flush  out  1  squash the IF/ID register.
id_ex_flush  out  1  squash the ID/EX register (bubble).
if_id_stall  out  1  hold the IF/ID register.
pipe_freeze  out  1  hold all pipeline registers.
epc_we  out  1  write trap_pc into the CSR mepc.
epc_out  out  DATA_W  value to write.
stall_cnt  out  CNT_W  count of cycles with pc_stall=1.

Behaviour:
- Reset (rst=0, async): state=RUN; pending cleared; all 1-bit outputs 0; new_pc=RESET_PC; epc_out=0; stall_cnt=0.
- States: RUN, TRAP, STALL, HALT. Outputs are combinational from state, inputs and pending (0-cycle latency, because the PC register samples on negedge).
- RUN redirect priority: trap > mret > ex_br > id_jump > sequential (new_pc = pc_in + PC_STEP, 32-bit wrap; 0xFFFF_FFFC -> 0x0).
  - trap: pc_stall=1, if_id_flush=1, id_ex_flush=1, epc_we=1, epc_out=trap_pc; next state TRAP.
  - mret: new_pc=mepc, if_id_flush=1, id_ex_flush=1.
  - ex_br: new_pc=ex_br_target, if_id_flush=1, id_ex_flush=1; overrides load_use.
  - id_jump: new_pc=id_jump_target, if_id_flush=1.
- TRAP (exactly 1 cycle): new_pc=trap_vector, pc_stall=0, if_id_flush=1; next state RUN. Requests in this cycle are ignored.
- load_use in RUN, with no trap/mret/ex_br: pc_stall=1, if_id_stall=1, id_ex_flush=1. A simultaneous id_jump is dropped; ID re-presents it.
- mem_busy (RUN or STALL): pc_stall=1, pipe_freeze=1, no flushes; state STALL while mem_busy=1.
  - mem_busy has precedence over every RUN action except trap, which always takes effect immediately.
- Pending buffer (kind + target): a redirect requested during STALL, or in the cycle mem_busy rises, is latched.
  - A higher-priority kind overwrites the buffer; equal or lower priority is dropped.
  - In the first cycle with mem_busy=0, the pending redirect is applied exactly as in RUN, the buffer clears, and the state goes to RUN.
- HALT: entered from RUN on halt_req when no redirect or stall is active. Holds pc_stall=1 and pipe_freeze=1 until resume=1, then returns to RUN; that cycle outputs sequential new_pc.
- stall_cnt: +1 on every posedge with pc_stall=1; saturates at all-ones; stall_cnt_clr has priority over the increment.
- Async reset mid-TRAP or mid-STALL: pending dropped, epc_we deasserted immediately.

Decomposition:
- Package pc_ctrl_pkg holds:
  - typedef enum state_t {RUN, TRAP, STALL, HALT};
  - typedef enum redir_kind_t {R_NONE, R_JUMP, R_BR, R_MRET, R_TRAP}, encoded in ascending priority so the buffer compares kinds numerically;
  - the PC_STEP and RESET_PC defaults.
- One sub-module, redirect_arb: combinational priority encoder returning kind and target from the request/target inputs. It is shared by the RUN path and the pending-capture path.

Test Plan:
1. Reset: rst=0 with pc_in=0x40 -> new_pc=0, all flags 0, stall_cnt=0. Release rst, pc_in=0x40 -> new_pc=0x44.
2. Same-cycle conflict: ex_br_req (target 0x100) + id_jump_req (target 0x200) + load_use -> new_pc=0x100, both flushes=1, pc_stall=0.
3. Trap: trap_req with trap_pc=0x88, trap_vector=0x1C0 -> cycle0: pc_stall=1, epc_we=1, epc_out=0x88. Cycle1: new_pc=0x1C0, if_id_flush=1. Cycle2: state RUN.
4. Buffered redirect during stall:
   - mem_busy high for 3 cycles; id_jump_req (0x300) in cycle 1, then ex_br_req (0x500) in cycle 2 -> pc_stall=1 and pipe_freeze=1 for 3 cycles.
   - Next cycle: new_pc=0x500, both flushes; stall_cnt=3.
5. Load-use: load_use for 1 cycle, pc_in=0x20 -> pc_stall=1, if_id_stall=1, id_ex_flush=1. Next cycle new_pc=0x24.
6. Edge cases:
   - pc_in=0xFFFF_FFFC -> new_pc=0.
   - stall_cnt preloaded near saturation (CNT_W=4 build) stays at 0xF.
   - rst asserted mid-STALL with pending set, then released -> pending lost; sequential fetch resumes.
